// File: rtl/cosim_constants_pkg.sv
// cosim_constants_pkg: shared widths, the buffered reg-write item and checker states
package cosim_constants_pkg;
    localparam int REG_ID_W  = 16;
    localparam int REGNO_LSB = 4;
    localparam int ITEM_XLEN = 64;

    typedef struct packed {
        logic [REG_ID_W-1:0]  id;
        logic [ITEM_XLEN-1:0] data;
    } reg_write_item_t;

    typedef enum logic {RUN, ERROR} chk_state_e;
endpackage

// File: rtl/cosim_sync_fifo.sv
// cosim_sync_fifo: synchronous FIFO of reg-write items with level, flush and head peek
module cosim_sync_fifo import cosim_constants_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  reg_write_item_t        din_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output reg_write_item_t        head_o
);
    localparam int AW = $clog2(DEPTH);

    reg_write_item_t r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_level;
    logic            w_push;
    logic            w_pop;

    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign full_o  = r_level == (AW+1)'(DEPTH);
    assign empty_o = r_level == '0;
    assign level_o = r_level;
    assign head_o  = r_mem[r_rp];

    // Pointers wrap naturally since DEPTH is a power of two; flush behaves like reset
    always_ff @(posedge clk_i) begin
        if (rst_i | flush_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read as valid
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= din_i;
    end
endmodule

// File: rtl/cosim_reg_write_checker.sv
// cosim_reg_write_checker: buffers Spike reg-write entries and checks DUT commits in order
module cosim_reg_write_checker import cosim_constants_pkg::*; #(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 64,
    parameter bit FILTER_X0 = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   exp_valid_i,
    output logic                   exp_ready_o,
    input  logic [REG_ID_W-1:0]    exp_reg_id_i,
    input  logic [XLEN-1:0]        exp_data_i,
    input  logic                   dut_valid_i,
    input  logic [REG_ID_W-1:0]    dut_reg_id_i,
    input  logic [XLEN-1:0]        dut_data_i,
    output logic                   error_o,
    output logic                   error_pulse_o,
    output logic                   underflow_o,
    output logic [REG_ID_W-1:0]    err_exp_id_o,
    output logic [XLEN-1:0]        err_exp_data_o,
    output logic [REG_ID_W-1:0]    err_dut_id_o,
    output logic [XLEN-1:0]        err_dut_data_o,
    output logic [31:0]            match_count_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o
);
    chk_state_e      r_state;
    reg_write_item_t w_head;
    reg_write_item_t w_din;
    logic            w_full;
    logic            w_run;
    logic            w_x0;
    logic            w_push;
    logic            w_pop;
    logic            w_match;

    assign w_run       = r_state == RUN;
    assign exp_ready_o = w_run ? ~w_full : 1'b1;
    assign w_x0        = FILTER_X0 && exp_reg_id_i[REG_ID_W-1:REGNO_LSB] == '0;
    assign w_din       = '{id: exp_reg_id_i, data: ITEM_XLEN'(exp_data_i)};
    assign w_push      = w_run & exp_valid_i & ~w_full & ~w_x0;
    assign w_pop       = w_run & dut_valid_i & ~empty_o;
    assign w_match     = w_head.id == dut_reg_id_i && w_head.data[XLEN-1:0] == dut_data_i;

    cosim_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .full_o  (w_full),
        .empty_o (empty_o),
        .level_o (level_o),
        .head_o  (w_head)
    );

    // Compare each commit against the head; the first divergence freezes captures until cleared
    always_ff @(posedge clk_i) begin
        if (rst_i | clear_i) begin
            r_state        <= RUN;
            error_o        <= 1'b0;
            error_pulse_o  <= 1'b0;
            underflow_o    <= 1'b0;
            err_exp_id_o   <= '0;
            err_exp_data_o <= '0;
            err_dut_id_o   <= '0;
            err_dut_data_o <= '0;
            match_count_o  <= '0;
        end else begin
            error_pulse_o <= 1'b0;
            if (w_run & dut_valid_i) begin
                if (empty_o | ~w_match) begin
                    r_state        <= ERROR;
                    error_o        <= 1'b1;
                    error_pulse_o  <= 1'b1;
                    underflow_o    <= empty_o;
                    err_exp_id_o   <= empty_o ? '0 : w_head.id;
                    err_exp_data_o <= empty_o ? '0 : w_head.data[XLEN-1:0];
                    err_dut_id_o   <= dut_reg_id_i;
                    err_dut_data_o <= dut_data_i;
                end else begin
                    match_count_o <= match_count_o + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cosim_reg_write_checker.sv
// tb_cosim_reg_write_checker: directed scenarios plus random traffic against a queue model
module tb_cosim_reg_write_checker;
    localparam int DEPTH = 16;
    localparam int XLEN  = 64;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk_i = 1'b0;
    logic            rst_i, clear_i, exp_valid_i, dut_valid_i;
    logic [15:0]     exp_reg_id_i, dut_reg_id_i;
    logic [XLEN-1:0] exp_data_i, dut_data_i;
    logic            exp_ready_o, error_o, error_pulse_o, underflow_o, empty_o;
    logic [15:0]     err_exp_id_o, err_dut_id_o;
    logic [XLEN-1:0] err_exp_data_o, err_dut_data_o;
    logic [31:0]     match_count_o;
    logic [LW-1:0]   level_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]     id;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic            m_err, m_pulse, m_uf;
    logic [15:0]     m_eid, m_did;
    logic [XLEN-1:0] m_ed, m_dd;
    logic [31:0]     m_cnt;

    cosim_reg_write_checker #(.DEPTH(DEPTH), .XLEN(XLEN), .FILTER_X0(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o),
        .exp_reg_id_i(exp_reg_id_i), .exp_data_i(exp_data_i),
        .dut_valid_i(dut_valid_i), .dut_reg_id_i(dut_reg_id_i), .dut_data_i(dut_data_i),
        .error_o(error_o), .error_pulse_o(error_pulse_o), .underflow_o(underflow_o),
        .err_exp_id_o(err_exp_id_o), .err_exp_data_o(err_exp_data_o),
        .err_dut_id_o(err_dut_id_o), .err_dut_data_o(err_dut_data_o),
        .match_count_o(match_count_o), .level_o(level_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        rst_i = 0; clear_i = 0;
        exp_valid_i = 0; exp_reg_id_i = '0; exp_data_i = '0;
        dut_valid_i = 0; dut_reg_id_i = '0; dut_data_i = '0;
    endtask

    // Advance the model by one cycle from the current inputs, then clock the DUT
    task automatic tick();
        bit   rdy;
        ent_t h;
        if (rst_i || clear_i) begin
            mq.delete();
            m_err = 0; m_pulse = 0; m_uf = 0;
            m_eid = '0; m_ed = '0; m_did = '0; m_dd = '0; m_cnt = '0;
        end else begin
            m_pulse = 0;
            if (!m_err) begin
                rdy = mq.size() < DEPTH;
                if (dut_valid_i) begin
                    if (mq.size() == 0) begin
                        m_err = 1; m_pulse = 1; m_uf = 1;
                        m_eid = '0; m_ed = '0; m_did = dut_reg_id_i; m_dd = dut_data_i;
                    end else begin
                        h = mq.pop_front();
                        if (h.id == dut_reg_id_i && h.data == dut_data_i) m_cnt = m_cnt + 1;
                        else begin
                            m_err = 1; m_pulse = 1;
                            m_eid = h.id; m_ed = h.data; m_did = dut_reg_id_i; m_dd = dut_data_i;
                        end
                    end
                end
                if (exp_valid_i && rdy && exp_reg_id_i[15:4] != 0) mq.push_back('{exp_reg_id_i, exp_data_i});
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit ev, input logic [15:0] eid, input logic [XLEN-1:0] ed,
                         input bit dv, input logic [15:0] did, input logic [XLEN-1:0] dd);
        exp_valid_i = ev; exp_reg_id_i = eid; exp_data_i = ed;
        dut_valid_i = dv; dut_reg_id_i = did; dut_data_i = dd;
        tick();
        idle();
    endtask

    task automatic do_clear();
        clear_i = 1;
        tick();
        clear_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        tick();
        rst_i = 0;
        checks++;
        if ({error_o, error_pulse_o, underflow_o, match_count_o, err_exp_id_o, err_dut_id_o} !== '0) begin
            errors++; $display("FAIL reset_flags: got err=%b pulse=%b uf=%b cnt=%0d expected all 0", error_o, error_pulse_o, underflow_o, match_count_o);
        end
        checks++;
        if (level_o !== 0 || empty_o !== 1'b1 || exp_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_buffer: got level=%0d empty=%b ready=%b expected 0/1/1", level_o, empty_o, exp_ready_o);
        end
    endtask

    task automatic test_match();
        do_clear();
        drive(1, 16'h0051, 64'hAA, 0, '0, '0);
        drive(1, 16'h0061, 64'hBB, 0, '0, '0);
        drive(0, '0, '0, 1, 16'h0051, 64'hAA);
        drive(0, '0, '0, 1, 16'h0061, 64'hBB);
        checks++;
        if (match_count_o !== 32'd2 || empty_o !== 1'b1 || error_o !== 1'b0) begin
            errors++; $display("FAIL match_pair: got cnt=%0d empty=%b err=%b expected 2/1/0", match_count_o, empty_o, error_o);
        end
    endtask

    task automatic test_mismatch();
        do_clear();
        drive(1, 16'h0051, 64'hAA, 0, '0, '0);
        drive(0, '0, '0, 1, 16'h0051, 64'hAB);
        checks++;
        if (error_pulse_o !== 1'b1 || error_o !== 1'b1 || underflow_o !== 1'b0) begin
            errors++; $display("FAIL mismatch_flags: got pulse=%b err=%b uf=%b expected 1/1/0", error_pulse_o, error_o, underflow_o);
        end
        checks++;
        if (err_exp_data_o !== 64'hAA || err_dut_data_o !== 64'hAB || err_exp_id_o !== 16'h0051 || err_dut_id_o !== 16'h0051) begin
            errors++; $display("FAIL mismatch_capture: got exp=%h/%h dut=%h/%h expected 0051/aa 0051/ab", err_exp_id_o, err_exp_data_o, err_dut_id_o, err_dut_data_o);
        end
        drive(1, 16'h0071, 64'h1, 1, 16'h0099, 64'h2);
        checks++;
        if (error_pulse_o !== 1'b0 || error_o !== 1'b1 || err_dut_data_o !== 64'hAB || level_o !== 0 || exp_ready_o !== 1'b1) begin
            errors++; $display("FAIL error_hold: got pulse=%b err=%b dut_data=%h level=%0d ready=%b expected 0/1/ab/0/1", error_pulse_o, error_o, err_dut_data_o, level_o, exp_ready_o);
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < DEPTH; i++) drive(1, {12'(i + 1), 4'h1}, 64'(i + 100), 0, '0, '0);
        checks++;
        if (exp_ready_o !== 1'b0 || level_o !== LW'(DEPTH)) begin
            errors++; $display("FAIL full: got ready=%b level=%0d expected 0/16", exp_ready_o, level_o);
        end
        drive(1, 16'h0FF1, 64'h5, 1, 16'h0011, 64'd100);
        checks++;
        if (exp_ready_o !== 1'b1 || level_o !== LW'(DEPTH - 1) || match_count_o !== 32'd1) begin
            errors++; $display("FAIL full_pop: got ready=%b level=%0d cnt=%0d expected 1/15/1", exp_ready_o, level_o, match_count_o);
        end
        drive(1, 16'h1001, 64'h7, 1, 16'h0021, 64'd101);
        checks++;
        if (level_o !== LW'(DEPTH - 1) || match_count_o !== 32'd2 || error_o !== 1'b0) begin
            errors++; $display("FAIL push_pop: got level=%0d cnt=%0d err=%b expected 15/2/0", level_o, match_count_o, error_o);
        end
    endtask

    task automatic test_filter();
        do_clear();
        drive(1, 16'h0001, 64'h11, 0, '0, '0);
        drive(1, 16'h0011, 64'h22, 0, '0, '0);
        checks++;
        if (level_o !== 1) begin
            errors++; $display("FAIL filter_level: got %0d expected 1", level_o);
        end
        drive(0, '0, '0, 1, 16'h0011, 64'h22);
        checks++;
        if (match_count_o !== 32'd1 || error_o !== 1'b0 || level_o !== 0) begin
            errors++; $display("FAIL filter_match: got cnt=%0d err=%b level=%0d expected 1/0/0", match_count_o, error_o, level_o);
        end
    endtask

    task automatic test_underflow_clear();
        do_clear();
        drive(1, 16'h0071, 64'hCC, 1, 16'h0081, 64'hDD);
        checks++;
        if (underflow_o !== 1'b1 || error_o !== 1'b1 || error_pulse_o !== 1'b1 || err_exp_id_o !== 16'h0 || err_exp_data_o !== 64'h0) begin
            errors++; $display("FAIL underflow: got uf=%b err=%b pulse=%b exp_id=%h exp_data=%h expected 1/1/1/0/0", underflow_o, error_o, error_pulse_o, err_exp_id_o, err_exp_data_o);
        end
        checks++;
        if (err_dut_id_o !== 16'h0081 || err_dut_data_o !== 64'hDD || level_o !== 1) begin
            errors++; $display("FAIL underflow_capture: got dut=%h/%h level=%0d expected 0081/dd/1", err_dut_id_o, err_dut_data_o, level_o);
        end
        do_clear();
        checks++;
        if ({error_o, underflow_o, error_pulse_o, err_dut_id_o, err_dut_data_o, match_count_o, level_o} !== '0 || empty_o !== 1'b1) begin
            errors++; $display("FAIL clear: got err=%b uf=%b dut=%h/%h level=%0d expected all 0", error_o, underflow_o, err_dut_id_o, err_dut_data_o, level_o);
        end
        drive(1, 16'h0091, 64'hEE, 0, '0, '0);
        drive(0, '0, '0, 1, 16'h0091, 64'hEE);
        checks++;
        if (match_count_o !== 32'd1 || error_o !== 1'b0) begin
            errors++; $display("FAIL after_clear: got cnt=%0d err=%b expected 1/0", match_count_o, error_o);
        end
    endtask

    task automatic test_reset_midstream();
        do_clear();
        for (int i = 0; i < 7; i++) drive(1, {12'(i + 3), 4'h2}, 64'(i * 3 + 1), 0, '0, '0);
        drive(0, '0, '0, 1, 16'h0032, 64'd1);
        drive(0, '0, '0, 1, 16'h0042, 64'd99);
        checks++;
        if (level_o !== 5 || error_o !== 1'b1 || match_count_o !== 32'd1) begin
            errors++; $display("FAIL pre_reset: got level=%0d err=%b cnt=%0d expected 5/1/1", level_o, error_o, match_count_o);
        end
        rst_i = 1;
        tick();
        rst_i = 0;
        checks++;
        if (level_o !== 0 || error_o !== 1'b0 || match_count_o !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got level=%0d err=%b cnt=%0d expected 0/0/0", level_o, error_o, match_count_o);
        end
    endtask

    task automatic test_random();
        logic [LW-1:0] m_level;
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            clear_i      = ($urandom % 100) < 2;
            exp_valid_i  = $urandom % 2;
            exp_reg_id_i = {12'($urandom % 6), 4'($urandom % 3)};
            exp_data_i   = {$urandom, $urandom};
            dut_valid_i  = mq.size() > 0 ? ($urandom % 100) < 40 : ($urandom % 100) < 3;
            if (mq.size() > 0 && $urandom % 40 != 0) begin
                dut_reg_id_i = mq[0].id;
                dut_data_i   = mq[0].data;
            end else begin
                dut_reg_id_i = 16'($urandom);
                dut_data_i   = {$urandom, $urandom};
            end
            tick();
            m_level = LW'(mq.size());
            checks++;
            if ({level_o, empty_o, exp_ready_o, error_o, error_pulse_o, underflow_o, match_count_o}
                !== {m_level, mq.size() == 0, m_err || mq.size() < DEPTH, m_err, m_pulse, m_uf, m_cnt}) begin
                errors++; $display("FAIL random_status cycle %0d: got level=%0d empty=%b ready=%b err=%b pulse=%b uf=%b cnt=%0d expected %0d/%b/%b/%b/%b/%b/%0d",
                    c, level_o, empty_o, exp_ready_o, error_o, error_pulse_o, underflow_o, match_count_o,
                    m_level, mq.size() == 0, m_err || mq.size() < DEPTH, m_err, m_pulse, m_uf, m_cnt);
            end
            checks++;
            if ({err_exp_id_o, err_exp_data_o, err_dut_id_o, err_dut_data_o} !== {m_eid, m_ed, m_did, m_dd}) begin
                errors++; $display("FAIL random_capture cycle %0d: got %h/%h %h/%h expected %h/%h %h/%h",
                    c, err_exp_id_o, err_exp_data_o, err_dut_id_o, err_dut_data_o, m_eid, m_ed, m_did, m_dd);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_match();
        test_mismatch();
        test_full();
        test_filter();
        test_underflow_clear();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
